// File: rtl/quad_filter_decoder.sv
// Filtered quadrature decoder: sync, deglitch, Gray-step count.
// Optional err_count port: QUAD_FILTER_DECODER_ERR_COUNT_EN.
module quad_filter_decoder #(
  parameter int size     = 8,
  parameter int filt_len = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      q,
  input  logic            clr_err,
  output logic [size-1:0] count,
  output logic            dir,
`ifdef QUAD_FILTER_DECODER_ERR_COUNT_EN
  output logic            err,
  output logic [3:0]      err_count
`else
  output logic            err
`endif
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] flen_m1 = 4'(filt_len - 1);

  state_t          state;
  state_t          state_nx;
  logic            init_cnt;
  logic            run;
  logic            load;
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      f;
  logic [1:0]      p;
  logic [1:0][3:0] fc;
  logic            fwd;
  logic            rev;
  logic            bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      init_cnt <= 1'b0;
    end else begin
      state    <= state_nx;
      init_cnt <= (state == INIT) && !init_cnt;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT: if (init_cnt) state_nx = RUN;
      RUN:  state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  always_comb begin
    run  = 1'b0;
    load = 1'b0;
    unique case (state)
      INIT: load = init_cnt;
      RUN:  run  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= q;
      s2 <= s1;
    end
  end

  // On the load edge s2 takes s1, so adopt that level directly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f  <= '0;
      fc <= '0;
    end else if (load) begin
      f  <= s1;
      fc <= '0;
    end else if (run) begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == f[i]) begin
          fc[i] <= '0;
        end else if (fc[i] == flen_m1) begin
          f[i]  <= s2[i];
          fc[i] <= '0;
        end else begin
          fc[i] <= fc[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    fwd = (f == {p[0], ~p[1]});
    rev = (f == {~p[0], p[1]});
    bad = (f == ~p);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p     <= '0;
      count <= '0;
      dir   <= 1'b0;
    end else if (load) begin
      p <= s1;
    end else if (run) begin
      p <= f;
      unique case (1'b1)
        fwd: begin
          count <= count + size'(1);
          dir   <= 1'b1;
        end
        rev: begin
          count <= count - size'(1);
          dir   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (run && bad) begin
      err <= 1'b1;
    end else if (run && clr_err) begin
      err <= 1'b0;
    end
  end

`ifdef QUAD_FILTER_DECODER_ERR_COUNT_EN
  // A clear coinciding with a new error restarts the tally at one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (run && bad) begin
      if (clr_err)
        err_count <= 4'd1;
      else if (err_count != 4'd15)
        err_count <= err_count + 4'd1;
    end else if (run && clr_err) begin
      err_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_quad_filter_decoder.sv
// Self-checking bench for quad_filter_decoder (size 8, filt_len 3).
// Step-level reference model: Gray index arithmetic per settled step.
module tb_quad_filter_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] q;
  logic       clr_err;
  logic [7:0] count;
  logic       dir;
  logic       err;
`ifdef QUAD_FILTER_DECODER_ERR_COUNT_EN
  logic [3:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  int         m_count;
  logic       m_dir;
  logic       m_err;
  int         m_ec;
  logic [1:0] m_pos;

  always #5 clk = ~clk;

  quad_filter_decoder #(
    .size(8),
    .filt_len(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q(q),
    .clr_err(clr_err),
    .count(count),
    .dir(dir),
`ifdef QUAD_FILTER_DECODER_ERR_COUNT_EN
    .err(err),
    .err_count(err_count)
`else
    .err(err)
`endif
  );

  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, int'(count), m_count);
    chk({tag, ".dir"}, int'(dir), int'(m_dir));
    chk({tag, ".err"}, int'(err), int'(m_err));
`ifdef QUAD_FILTER_DECODER_ERR_COUNT_EN
    chk({tag, ".err_count"}, int'(err_count), m_ec);
`endif
  endtask

  // Effect of a settled move from m_pos to v, in Gray-index terms
  task automatic model_move(input logic [1:0] v, input logic clr);
    int d;
    d = (gidx(v) - gidx(m_pos) + 4) % 4;
    if (d == 1) begin
      m_count = (m_count + 1) % 256;
      m_dir = 1'b1;
    end else if (d == 3) begin
      m_count = (m_count + 255) % 256;
      m_dir = 1'b0;
    end else if (d == 2) begin
      m_err = 1'b1;
      m_ec = clr ? 1 : ((m_ec < 15) ? m_ec + 1 : 15);
    end
    m_pos = v;
  endtask

  task automatic apply(input logic [1:0] v, input int hold);
    q = v;
    model_move(v, 1'b0);
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] v);
    rst = 1'b0;
    q = v;
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_count = 0;
    m_dir = 1'b0;
    m_err = 1'b0;
    m_ec = 0;
    m_pos = v;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic [7:0] c0;
    logic [1:0] nv;
    int r;

    rst = 1'b0;
    q = 2'b11;
    clr_err = 1'b0;
    m_count = 0;
    m_dir = 1'b0;
    m_err = 1'b0;
    m_ec = 0;
    m_pos = 2'b11;
    repeat (2) @(negedge clk);
    chk_all("in_reset");

    // Resting at 11 through reset release: no spurious step
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk_all("rest_11");

    do_reset(2'b00);
    c0 = count;
    q = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) chk("lat_edge5", int'(count), int'(c0));
      if (k == 6) chk("lat_edge6", int'(count), int'(c0) + 1);
    end
    @(negedge clk);
    model_move(2'b01, 1'b0);
    repeat (8) @(negedge clk);
    apply(2'b11, 10);
    apply(2'b10, 10);
    apply(2'b00, 10);
    chk_all("fwd4");
    chk("fwd4_val", int'(count), 4);

    do_reset(2'b00);
    apply(2'b10, 10);
    chk_all("rev_wrap");
    chk("rev_wrap_val", int'(count), 255);
    for (int i = 0; i < 256; i++) begin
      nv = m_pos;
      case (nv)
        2'b00:   nv = 2'b01;
        2'b01:   nv = 2'b11;
        2'b11:   nv = 2'b10;
        default: nv = 2'b00;
      endcase
      apply(nv, 5);
    end
    repeat (5) @(negedge clk);
    chk_all("fwd256");
    chk("fwd256_val", int'(count), 255);

    // Two-cycle glitch on A is rejected
    q = 2'b11;
    repeat (2) @(negedge clk);
    q = 2'b10;
    repeat (12) @(negedge clk);
    chk_all("glitch2");
    apply(2'b11, 10);
    chk_all("hold3");

    apply(2'b00, 10);
    chk_all("illegal1");
    for (int i = 0; i < 20; i++)
      apply((i % 2 == 0) ? 2'b11 : 2'b00, 8);
    chk_all("illegal21");

    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_err = 1'b0;
    m_ec = 0;
    repeat (3) @(negedge clk);
    chk_all("clr");

    apply(2'b11, 10);
    chk_all("pre_coinc");
    // Illegal step decodes on the 6th posedge; clear on that edge
    q = 2'b00;
    repeat (5) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    model_move(2'b00, 1'b1);
    repeat (4) @(negedge clk);
    chk_all("coinc");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      nv = m_pos;
      if (r < 4)       nv = {m_pos[0], ~m_pos[1]};
      else if (r < 7)  nv = {~m_pos[0], m_pos[1]};
      else if (r == 7) nv = ~m_pos;
      apply(nv, $urandom_range(7, 10));
      chk_all($sformatf("rnd%0d", i));
    end

    // Async reset in the middle of a pending step
    apply({m_pos[0], ~m_pos[1]}, 10);
    q = {m_pos[0], ~m_pos[1]};
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    m_count = 0;
    m_dir = 1'b0;
    m_err = 1'b0;
    m_ec = 0;
    m_pos = q;
    chk_all("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("post_rst_init");
    repeat (20) @(negedge clk);
    chk_all("post_rst_run");
    apply({m_pos[0], ~m_pos[1]}, 10);
    chk_all("post_rst_step");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
